// File: rtl/btb_upd_sched.sv
`default_nettype none
// ============================================================================
// Module   : btb_upd_sched
// Purpose  : Schedules branch-predictor table updates and front-end redirects
//            for branches resolving in EX. Resolved branches are queued in a
//            4-entry FIFO and offered to the table write port with a
//            valid/ready handshake. A mispredict raises a one-cycle flush
//            with a registered redirect target. A HOLD cycle then drops the
//            wrong-path EX instruction.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n          : clock; synchronous active-low reset
//   ex_valid/ex_branch  : EX slot holds a real conditional branch
//   ex_taken            : resolved direction
//   ex_hit/ex_hitpos    : table hit at fetch and the matched entry index
//   ex_preright         : prediction matched the outcome (valid when ex_hit)
//   ex_pc/ex_npc        : branch PC and resolved next PC
//   ex_stall            : EX must hold because the queue is full and blocked
//   flush/redirect_pc   : one-cycle IF/ID kill and the fetch target
//   upd_valid/upd_ready : update-record handshake to the table write port
//   upd_pc, upd_npc, upd_hitpos, upd_hit, upd_preright : head record fields
//   br_cnt/mis_cnt      : saturating resolved-branch / mispredict counters
// ============================================================================
module btb_upd_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_taken,
    input  logic        ex_hit,
    input  logic [2:0]  ex_hitpos,
    input  logic        ex_preright,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_npc,
    output logic        ex_stall,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        upd_valid,
    input  logic        upd_ready,
    output logic [31:0] upd_pc,
    output logic [31:0] upd_npc,
    output logic [2:0]  upd_hitpos,
    output logic        upd_hit,
    output logic        upd_preright,
    output logic [15:0] br_cnt,
    output logic [15:0] mis_cnt
);

    // Record layout: {pc, npc, hitpos, hit, preright}
    localparam int         c_REC_W    = 69;
    localparam logic [2:0] c_DEPTH    = 3'd4;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FLUSH = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [c_REC_W-1:0] r_mem [0:3];
    logic [1:0]         r_wr_ptr;
    logic [1:0]         r_rd_ptr;
    logic [2:0]         r_count;
    logic [1:0]         r_state;
    logic               r_flush;
    logic [31:0]        r_redirect_pc;
    logic [15:0]        r_br_cnt;
    logic [15:0]        r_mis_cnt;

    logic               w_resolve;
    logic               w_accept;
    logic               w_mispredict;
    logic               w_push;
    logic               w_pop;
    logic [c_REC_W-1:0] w_head;

    // A full queue only blocks EX when the head is not leaving this cycle;
    // a pop frees the slot the incoming push needs.
    assign ex_stall     = (r_count == c_DEPTH) & ~upd_ready;
    assign w_resolve    = ex_valid & ex_branch & ~ex_stall;
    // During HOLD the EX slot is wrong-path and must leave no trace.
    assign w_accept     = w_resolve & (r_state != c_ST_HOLD);
    assign w_mispredict = w_accept & (ex_hit ? ~ex_preright : ex_taken);
    assign w_push       = w_accept;

    assign upd_valid = (r_count != 3'd0);
    assign w_pop     = upd_valid & upd_ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign {upd_pc, upd_npc, upd_hitpos, upd_hit, upd_preright} = w_head;

    assign flush       = r_flush;
    assign redirect_pc = r_redirect_pc;
    assign br_cnt      = r_br_cnt;
    assign mis_cnt     = r_mis_cnt;

    // Storage needs no reset; validity is carried by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {ex_pc, ex_npc, ex_hitpos, ex_hit, ex_preright};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_br_cnt  <= 16'd0;
            r_mis_cnt <= 16'd0;
        end else begin
            if (w_accept && (r_br_cnt != c_CNT_MAX)) begin
                r_br_cnt <= r_br_cnt + 16'd1;
            end
            if (w_mispredict && (r_mis_cnt != c_CNT_MAX)) begin
                r_mis_cnt <= r_mis_cnt + 16'd1;
            end
        end
    end

    // Redirect FSM. Only IDLE reacts to a mispredict, so a second one
    // arriving during FLUSH cannot retarget the fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_flush       <= 1'b0;
            r_redirect_pc <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_mispredict) begin
                        r_state       <= c_ST_FLUSH;
                        r_flush       <= 1'b1;
                        r_redirect_pc <= ex_taken ? ex_npc : (ex_pc + 32'd1);
                    end
                end
                c_ST_FLUSH: begin
                    r_state <= c_ST_HOLD;
                    r_flush <= 1'b0;
                end
                c_ST_HOLD: begin
                    r_state <= c_ST_IDLE;
                    r_flush <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btb_upd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_btb_upd_sched
// Purpose  : Self-checking bench for btb_upd_sched. A negedge monitor keeps
//            a reference queue and redirect model and compares every popped
//            record. Scenario tasks add directed checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btb_upd_sched;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_taken;
    logic        ex_hit;
    logic [2:0]  ex_hitpos;
    logic        ex_preright;
    logic [31:0] ex_pc;
    logic [31:0] ex_npc;
    logic        ex_stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [31:0] upd_npc;
    logic [2:0]  upd_hitpos;
    logic        upd_hit;
    logic        upd_preright;
    logic [15:0] br_cnt;
    logic [15:0] mis_cnt;

    int checks;
    int failures;
    int dut_pops;
    bit mon_en;

    // Reference model state
    logic [68:0] sb [$];
    logic [68:0] m_rec;
    logic [1:0]  m_state;
    logic [15:0] m_br;
    logic [15:0] m_mis;
    logic [31:0] m_redirect;
    logic        m_stall;
    logic        m_acc;
    logic        m_mp;

    btb_upd_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_branch    (ex_branch),
        .ex_taken     (ex_taken),
        .ex_hit       (ex_hit),
        .ex_hitpos    (ex_hitpos),
        .ex_preright  (ex_preright),
        .ex_pc        (ex_pc),
        .ex_npc       (ex_npc),
        .ex_stall     (ex_stall),
        .flush        (flush),
        .redirect_pc  (redirect_pc),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_pc       (upd_pc),
        .upd_npc      (upd_npc),
        .upd_hitpos   (upd_hitpos),
        .upd_hit      (upd_hit),
        .upd_preright (upd_preright),
        .br_cnt       (br_cnt),
        .mis_cnt      (mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares outputs mid-cycle, then advances the model to
    // reflect the coming rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            m_stall = (sb.size() == 4) && !upd_ready;
            checks++;
            if (ex_stall !== m_stall) begin
                failures++;
                $display("FAIL mon_ex_stall t=%0t got=%b exp=%b", $time, ex_stall, m_stall);
            end
            checks++;
            if (upd_valid !== (sb.size() != 0)) begin
                failures++;
                $display("FAIL mon_upd_valid t=%0t got=%b exp=%b", $time, upd_valid, (sb.size() != 0));
            end
            checks++;
            if (flush !== (m_state == 2'd1)) begin
                failures++;
                $display("FAIL mon_flush t=%0t got=%b exp=%b", $time, flush, (m_state == 2'd1));
            end
            checks++;
            if (redirect_pc !== m_redirect) begin
                failures++;
                $display("FAIL mon_redirect_pc t=%0t got=%h exp=%h", $time, redirect_pc, m_redirect);
            end
            checks++;
            if (br_cnt !== m_br || mis_cnt !== m_mis) begin
                failures++;
                $display("FAIL mon_counters t=%0t got=%0d/%0d exp=%0d/%0d", $time, br_cnt, mis_cnt, m_br, m_mis);
            end
            if (upd_valid === 1'b1 && upd_ready === 1'b1) dut_pops++;

            if (rst_n === 1'b0) begin
                sb.delete();
                m_state    = 2'd0;
                m_br       = 16'd0;
                m_mis      = 16'd0;
                m_redirect = 32'd0;
            end else begin
                m_acc = ex_valid && ex_branch && !m_stall && (m_state != 2'd2);
                m_mp  = m_acc && (ex_hit ? !ex_preright : ex_taken);
                if (sb.size() != 0 && upd_ready) begin
                    m_rec = sb.pop_front();
                    checks++;
                    if ({upd_pc, upd_npc, upd_hitpos, upd_hit, upd_preright} !== m_rec) begin
                        failures++;
                        $display("FAIL mon_record t=%0t got=%h exp=%h", $time,
                                 {upd_pc, upd_npc, upd_hitpos, upd_hit, upd_preright}, m_rec);
                    end
                end
                if (m_acc) begin
                    sb.push_back({ex_pc, ex_npc, ex_hitpos, ex_hit, ex_preright});
                    if (m_br != 16'hFFFF) m_br = m_br + 16'd1;
                end
                if (m_mp && m_mis != 16'hFFFF) m_mis = m_mis + 16'd1;
                case (m_state)
                    2'd0: if (m_mp) begin
                        m_state    = 2'd1;
                        m_redirect = ex_taken ? ex_npc : (ex_pc + 32'd1);
                    end
                    2'd1:    m_state = 2'd2;
                    default: m_state = 2'd0;
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        ex_valid = 1'b0; ex_branch = 1'b0; ex_taken = 1'b0; ex_hit = 1'b0;
        ex_hitpos = 3'd0; ex_preright = 1'b0; ex_pc = 32'd0; ex_npc = 32'd0;
    endtask

    task automatic set_br(input logic [31:0] pc, input logic [31:0] npc, input logic hit,
                          input logic pre, input logic taken, input logic [2:0] pos);
        ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = taken; ex_hit = hit;
        ex_hitpos = pos; ex_preright = pre; ex_pc = pc; ex_npc = npc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; upd_ready = 1'b0; set_idle();
        step(); step();
        mon_en = 1'b1;
        step();
        checks++;
        if (upd_valid !== 1'b0 || ex_stall !== 1'b0 || flush !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b%b%b exp=000", upd_valid, ex_stall, flush);
        end
        checks++;
        if (br_cnt !== 16'd0 || mis_cnt !== 16'd0 || redirect_pc !== 32'd0) begin
            failures++;
            $display("FAIL reset_values got=%0d/%0d/%h exp=0/0/0", br_cnt, mis_cnt, redirect_pc);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        upd_ready = 1'b1;
        set_br(32'h10, 32'h20, 1'b1, 1'b1, 1'b1, 3'd3);
        #1;
        checks++;
        if (upd_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_no_bypass got=%b exp=0", upd_valid);
        end
        step();
        set_idle();
        checks++;
        if (upd_valid !== 1'b1 || upd_pc !== 32'h10) begin
            failures++;
            $display("FAIL basic_offer got=%b/%h exp=1/00000010", upd_valid, upd_pc);
        end
        ex_valid = 1'b1; // non-branch instruction: nothing queued
        step();
        set_idle();
        checks++;
        if (upd_valid !== 1'b0 || flush !== 1'b0 || br_cnt !== 16'd1) begin
            failures++;
            $display("FAIL basic_after got=%b/%b/%0d exp=0/0/1", upd_valid, flush, br_cnt);
        end
    endtask

    task automatic test_mispredict();
        set_br(32'h50, 32'h40, 1'b0, 1'b0, 1'b1, 3'd1);
        step();
        set_idle();
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h40 || mis_cnt !== 16'd1 || br_cnt !== 16'd2) begin
            failures++;
            $display("FAIL mp_flush got=%b/%h/%0d/%0d exp=1/00000040/1/2", flush, redirect_pc, mis_cnt, br_cnt);
        end
        step();
        set_br(32'h60, 32'h64, 1'b1, 1'b1, 1'b1, 3'd2);
        checks++;
        if (flush !== 1'b0) begin
            failures++;
            $display("FAIL mp_one_cycle got=%b exp=0", flush);
        end
        step();
        set_idle();
        checks++;
        if (br_cnt !== 16'd2 || upd_valid !== 1'b0 || redirect_pc !== 32'h40) begin
            failures++;
            $display("FAIL mp_hold_drop got=%0d/%b/%h exp=2/0/00000040", br_cnt, upd_valid, redirect_pc);
        end
        step();
    endtask

    task automatic test_redirect_nt();
        set_br(32'h33, 32'h99, 1'b1, 1'b0, 1'b0, 3'd5);
        step();
        set_idle();
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h34 || mis_cnt !== 16'd2) begin
            failures++;
            $display("FAIL nt_redirect got=%b/%h/%0d exp=1/00000034/2", flush, redirect_pc, mis_cnt);
        end
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = dut_pops;
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_br(32'h100 + 32'(i * 4), 32'h180 + 32'(i * 4), 1'b1, 1'b1, 1'b1, 3'(i));
            step();
        end
        set_br(32'h110, 32'h190, 1'b1, 1'b1, 1'b1, 3'd4);
        #1;
        checks++;
        if (ex_stall !== 1'b1 || upd_pc !== 32'h100) begin
            failures++;
            $display("FAIL b2b_stall got=%b/%h exp=1/00000100", ex_stall, upd_pc);
        end
        step();
        checks++;
        if (ex_stall !== 1'b1 || upd_pc !== 32'h100 || br_cnt !== 16'd7) begin
            failures++;
            $display("FAIL b2b_held got=%b/%h/%0d exp=1/00000100/7", ex_stall, upd_pc, br_cnt);
        end
        upd_ready = 1'b1;
        #1;
        checks++;
        if (ex_stall !== 1'b0) begin
            failures++;
            $display("FAIL b2b_release got=%b exp=0", ex_stall);
        end
        step();
        set_idle();
        checks++;
        if (br_cnt !== 16'd8) begin
            failures++;
            $display("FAIL b2b_accept got=%0d exp=8", br_cnt);
        end
        repeat (6) step();
        checks++;
        if (upd_valid !== 1'b0 || (dut_pops - p0) != 5) begin
            failures++;
            $display("FAIL b2b_drain got=%b/%0d exp=0/5", upd_valid, dut_pops - p0);
        end
    endtask

    task automatic test_wrap();
        int p0;
        p0 = dut_pops;
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_br(32'h200 + 32'(i), 32'h280 + 32'(i), 1'b1, 1'b1, 1'b0, 3'(i));
            step();
        end
        upd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_br(32'h300 + 32'(i), 32'h380 + 32'(i), 1'b1, 1'b1, 1'(i & 1), 3'(i + 3));
            #1;
            checks++;
            if (ex_stall !== 1'b0 || upd_valid !== 1'b1) begin
                failures++;
                $display("FAIL wrap_flow i=%0d got=%b/%b exp=0/1", i, ex_stall, upd_valid);
            end
            step();
        end
        upd_ready = 1'b0;
        set_br(32'h3F0, 32'h3F4, 1'b1, 1'b1, 1'b1, 3'd7);
        #1;
        checks++;
        if (ex_stall !== 1'b1 || br_cnt !== 16'd22) begin
            failures++;
            $display("FAIL wrap_full got=%b/%0d exp=1/22", ex_stall, br_cnt);
        end
        set_idle();
        upd_ready = 1'b1;
        repeat (6) step();
        checks++;
        if (upd_valid !== 1'b0 || (dut_pops - p0) != 14) begin
            failures++;
            $display("FAIL wrap_drain got=%b/%0d exp=0/14", upd_valid, dut_pops - p0);
        end
    endtask

    task automatic test_reset_flush();
        int p0;
        upd_ready = 1'b0;
        set_br(32'h400, 32'h404, 1'b1, 1'b1, 1'b1, 3'd0);
        step();
        set_br(32'h404, 32'h408, 1'b1, 1'b1, 1'b1, 3'd1);
        step();
        set_br(32'h408, 32'h77, 1'b0, 1'b0, 1'b1, 3'd2);
        step();
        set_idle();
        checks++;
        if (flush !== 1'b1 || br_cnt !== 16'd25 || mis_cnt !== 16'd3) begin
            failures++;
            $display("FAIL rf_pre got=%b/%0d/%0d exp=1/25/3", flush, br_cnt, mis_cnt);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (flush !== 1'b0 || upd_valid !== 1'b0 || br_cnt !== 16'd0 || mis_cnt !== 16'd0) begin
            failures++;
            $display("FAIL rf_reset got=%b/%b/%0d/%0d exp=0/0/0/0", flush, upd_valid, br_cnt, mis_cnt);
        end
        rst_n = 1'b1;
        upd_ready = 1'b1;
        p0 = dut_pops;
        repeat (4) step();
        checks++;
        if (upd_valid !== 1'b0 || dut_pops != p0) begin
            failures++;
            $display("FAIL rf_discard got=%b/%0d exp=0/0", upd_valid, dut_pops - p0);
        end
    endtask

    initial begin
        checks = 0; failures = 0; dut_pops = 0; mon_en = 1'b0;
        m_state = 2'd0; m_br = 16'd0; m_mis = 16'd0; m_redirect = 32'd0;
        rst_n = 1'b0; upd_ready = 1'b0; set_idle();
        test_reset();
        test_basic();
        test_mispredict();
        test_redirect_nt();
        test_back_to_back();
        test_wrap();
        test_reset_flush();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/btb_upd_sched.md
BTB_UPD_SCHED -- requirements
Module: btb_upd_sched

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have the port ex_valid, input, 1 bit: the EX-stage slot holds a real instruction.
REQ-004 The block SHALL have the port ex_branch, input, 1 bit: the EX instruction is a conditional branch.
REQ-005 The block SHALL have the port ex_taken, input, 1 bit: the resolved branch direction.
REQ-006 The block SHALL have the port ex_hit, input, 1 bit: the predictor table hit when this instruction was fetched.
REQ-007 The block SHALL have the port ex_hitpos, input, 3 bits: the matched table entry index.
REQ-008 The block SHALL have the port ex_preright, input, 1 bit: the prediction matched the resolved outcome (meaningful only when ex_hit=1).
REQ-009 The block SHALL have the port ex_pc, input, 32 bits: the branch PC.
REQ-010 The block SHALL have the port ex_npc, input, 32 bits: the resolved next PC.
REQ-011 The block SHALL have the port ex_stall, output, 1 bit: hold EX because the queue cannot accept.
REQ-012 The block SHALL have the port flush, output, 1 bit: a one-cycle pulse that kills IF/ID.
REQ-013 The block SHALL have the port redirect_pc, output, 32 bits: the fetch target, valid while flush=1.
REQ-014 The block SHALL have the port upd_valid, output, 1 bit: an update record is offered to the table write port.
REQ-015 The block SHALL have the port upd_ready, input, 1 bit: the table write port accepts the record this cycle.
REQ-016 The block SHALL have the ports upd_pc (32 bits), upd_npc (32 bits), upd_hitpos (3 bits), upd_hit (1 bit) and upd_preright (1 bit), all outputs, carrying the head record fields.
REQ-017 The block SHALL have the port br_cnt, output, 16 bits: the number of resolved branches.
REQ-018 The block SHALL have the port mis_cnt, output, 16 bits: the number of mispredicted branches.

Function
REQ-019 The block SHALL define a resolve event as ex_valid & ex_branch & ~ex_stall.
REQ-020 The block SHALL define mispredict as resolve & (ex_hit ? ~ex_preright : ex_taken).
REQ-021 The block SHALL hold a 4-entry FIFO of records {pc, npc, hitpos, hit, preright}, with 2-bit read/write pointers that wrap 3->0 and a 3-bit occupancy count.
REQ-022 A resolve event SHALL push {ex_pc, ex_npc, ex_hitpos, ex_hit, ex_preright}; a non-branch or ex_valid=0 SHALL push nothing.
REQ-023 upd_valid SHALL equal (count != 0); the upd_* fields SHALL be combinational from the head entry.
REQ-024 A pop SHALL occur when upd_valid & upd_ready.
REQ-025 The upd_* fields SHALL stay stable while upd_valid=1 and upd_ready=0.
REQ-026 ex_stall SHALL equal (count == 4) & ~upd_ready, combinationally.
REQ-027 When count is 4 and a pop occurs, a push SHALL be allowed in the same cycle, and count SHALL remain 4.
REQ-028 A simultaneous push and pop at any count from 1 to 3 SHALL leave count unchanged.
REQ-029 A push at count 0 SHALL become visible on upd_valid in the next cycle; there SHALL be no bypass.
REQ-030 The redirect FSM SHALL have the states IDLE, FLUSH and HOLD.
REQ-031 In IDLE, a mispredict SHALL cause a transition to FLUSH and latch redirect_pc <= (ex_taken ? ex_npc : ex_pc+1).
REQ-032 In FLUSH, flush SHALL be 1 for exactly one cycle, followed by an unconditional transition to HOLD.
REQ-033 In HOLD, flush SHALL be 0, resolve events SHALL be ignored (a wrong-path EX, so no push and no count), and the next state SHALL be IDLE.
REQ-034 A mispredict arriving while in FLUSH SHALL be ignored.
REQ-035 redirect_pc SHALL hold its value outside FLUSH.
REQ-036 br_cnt SHALL increment on each accepted resolve, and mis_cnt SHALL increment on each accepted mispredict.
REQ-037 br_cnt and mis_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-038 When rst_n=0 at a clock edge, the block SHALL clear the FIFO pointers and count, return the FSM to IDLE, and clear flush, redirect_pc, br_cnt and mis_cnt to 0.
REQ-039 After reset, upd_valid and ex_stall SHALL be 0 in the next cycle.
REQ-040 Reset asserted mid-FLUSH or with records queued SHALL discard all queued records; none SHALL be offered afterwards.

Verification
REQ-041 The bench SHALL cover: reset, then a resolve with ex_hit=1, ex_preright=1, ex_pc=0x10, ex_npc=0x20 and upd_ready=1 -> upd_valid=1 next cycle with upd_pc=0x10, popped the following cycle, flush stays 0, br_cnt=1.
REQ-042 The bench SHALL cover: a resolve with ex_hit=0, ex_taken=1, ex_npc=0x40 -> flush=1 for one cycle with redirect_pc=0x40, a branch in the following cycle not counted, mis_cnt=1.
REQ-043 The bench SHALL cover: a resolve with ex_hit=1, ex_preright=0, ex_taken=0, ex_pc=0x33 -> redirect_pc=0x34.
REQ-044 The bench SHALL cover: upd_ready=0 with 5 back-to-back branch resolves -> count=4, ex_stall=1 on the 5th, upd_pc unchanged; then upd_ready=1 -> the stalled branch is accepted that cycle and records drain in FIFO order.
REQ-045 The bench SHALL cover: 4 pushes, then wrap-around with pointers passing 3->0 and alternating push/pop for 10 cycles -> order preserved and count correct.
REQ-046 The bench SHALL cover: rst_n=0 during FLUSH with 3 records queued -> next cycle flush=0, upd_valid=0, and counters 0.
